// File: rtl/udp_sequencer.sv
// Micro-datapath sequencer: one register-transfer command per IDLE->OPER->WRITE->DONE pass.
// Optional PC-increment step enabled by macro UDP_PCINC_EN.
module udp_sequencer #(
    parameter int DATAWIDTH_MUX_SELECTION     = 6,
    parameter int DATAWIDTH_ALU_SELECTION     = 4,
    parameter int DATAWIDTH_DECODER_SELECTION = 6,
    parameter int DATAWIDTH_DECODER_OUT       = 38,
    parameter logic [DATAWIDTH_MUX_SELECTION-1:0] REGPC_SEL  = 6'd33,
    parameter logic [DATAWIDTH_MUX_SELECTION-1:0] CONST4_SEL = 6'd34,
    parameter logic [DATAWIDTH_ALU_SELECTION-1:0] ALU_ADD_OP = 4'd1
) (
    input  logic                                   SC_UDPSEQ_CLOCK_50,
    input  logic                                   SC_UDPSEQ_Reset_InLow,
    input  logic                                   SC_UDPSEQ_CmdValid_In,
    output logic                                   SC_UDPSEQ_CmdReady_Out,
    input  logic [DATAWIDTH_MUX_SELECTION-1:0]     SC_UDPSEQ_CmdSrcA_In,
    input  logic [DATAWIDTH_MUX_SELECTION-1:0]     SC_UDPSEQ_CmdSrcB_In,
    input  logic [DATAWIDTH_ALU_SELECTION-1:0]     SC_UDPSEQ_CmdAluOp_In,
    input  logic [DATAWIDTH_DECODER_SELECTION-1:0] SC_UDPSEQ_CmdDest_In,
    output logic [DATAWIDTH_MUX_SELECTION-1:0]     SC_UDPSEQ_MuxA_Out,
    output logic [DATAWIDTH_MUX_SELECTION-1:0]     SC_UDPSEQ_MuxB_Out,
    output logic [DATAWIDTH_ALU_SELECTION-1:0]     SC_UDPSEQ_AluSel_Out,
    output logic [DATAWIDTH_DECODER_SELECTION-1:0] SC_UDPSEQ_DecoderSel_Out,
    output logic                                   SC_UDPSEQ_WriteEn_Out,
    output logic                                   SC_UDPSEQ_Done_Out,
    output logic                                   SC_UDPSEQ_Error_Out,
    output logic [15:0]                            SC_UDPSEQ_OpCount_Out
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_OPER,
        S_WRITE,
`ifdef UDP_PCINC_EN
        S_PCINC,
`endif
        S_DONE
    } state_t;

    state_t                                 state_q, state_d;
    logic                                   ready_q, ready_d;
    logic [DATAWIDTH_MUX_SELECTION-1:0]     src_a_q, src_a_d, src_b_q, src_b_d;
    logic [DATAWIDTH_ALU_SELECTION-1:0]     alu_op_q, alu_op_d;
    logic [DATAWIDTH_DECODER_SELECTION-1:0] dest_q, dest_d;
    logic [DATAWIDTH_MUX_SELECTION-1:0]     mux_a_q, mux_a_d, mux_b_q, mux_b_d;
    logic [DATAWIDTH_ALU_SELECTION-1:0]     alu_sel_q, alu_sel_d;
    logic [DATAWIDTH_DECODER_SELECTION-1:0] dec_sel_q, dec_sel_d;
    logic                                   we_q, we_d;
    logic                                   done_q, done_d;
    logic                                   err_q, err_d;
    logic [15:0]                            cnt_q, cnt_d;
    logic                                   cmd_legal;

    assign cmd_legal = (32'(src_a_q) < DATAWIDTH_DECODER_OUT) &&
                       (32'(src_b_q) < DATAWIDTH_DECODER_OUT) &&
                       (32'(dest_q)  < DATAWIDTH_DECODER_OUT);

    // Every output is registered: the _d values below are what the next state shows.
    always_comb begin
        state_d   = state_q;
        ready_d   = 1'b0;
        src_a_d   = src_a_q;
        src_b_d   = src_b_q;
        alu_op_d  = alu_op_q;
        dest_d    = dest_q;
        mux_a_d   = '0;
        mux_b_d   = '0;
        alu_sel_d = '0;
        dec_sel_d = '0;
        we_d      = 1'b0;
        done_d    = 1'b0;
        err_d     = err_q;
        cnt_d     = cnt_q;
        case (state_q)
            S_IDLE: begin
                ready_d = 1'b1;
                if (SC_UDPSEQ_CmdValid_In && ready_q) begin
                    src_a_d   = SC_UDPSEQ_CmdSrcA_In;
                    src_b_d   = SC_UDPSEQ_CmdSrcB_In;
                    alu_op_d  = SC_UDPSEQ_CmdAluOp_In;
                    dest_d    = SC_UDPSEQ_CmdDest_In;
                    mux_a_d   = SC_UDPSEQ_CmdSrcA_In;
                    mux_b_d   = SC_UDPSEQ_CmdSrcB_In;
                    alu_sel_d = SC_UDPSEQ_CmdAluOp_In;
                    ready_d   = 1'b0;
                    state_d   = S_OPER;
                end
            end
            S_OPER: begin
                mux_a_d   = src_a_q;
                mux_b_d   = src_b_q;
                alu_sel_d = alu_op_q;
                dec_sel_d = dest_q;
                // Register 0 is hard-wired, so a write to it is silently dropped.
                we_d      = cmd_legal && (dest_q != '0);
                if (!cmd_legal)
                    err_d = 1'b1;
                state_d   = S_WRITE;
            end
            S_WRITE: begin
`ifdef UDP_PCINC_EN
                mux_a_d   = REGPC_SEL;
                mux_b_d   = CONST4_SEL;
                alu_sel_d = ALU_ADD_OP;
                dec_sel_d = REGPC_SEL;
                we_d      = 1'b1;
                state_d   = S_PCINC;
`else
                done_d    = 1'b1;
                cnt_d     = cnt_q + 16'd1;
                state_d   = S_DONE;
`endif
            end
`ifdef UDP_PCINC_EN
            S_PCINC: begin
                done_d  = 1'b1;
                cnt_d   = cnt_q + 16'd1;
                state_d = S_DONE;
            end
`endif
            S_DONE: begin
                ready_d = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge SC_UDPSEQ_CLOCK_50 or negedge SC_UDPSEQ_Reset_InLow) begin
        if (!SC_UDPSEQ_Reset_InLow) begin
            state_q   <= S_IDLE;
            ready_q   <= 1'b0;
            src_a_q   <= '0;
            src_b_q   <= '0;
            alu_op_q  <= '0;
            dest_q    <= '0;
            mux_a_q   <= '0;
            mux_b_q   <= '0;
            alu_sel_q <= '0;
            dec_sel_q <= '0;
            we_q      <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            ready_q   <= ready_d;
            src_a_q   <= src_a_d;
            src_b_q   <= src_b_d;
            alu_op_q  <= alu_op_d;
            dest_q    <= dest_d;
            mux_a_q   <= mux_a_d;
            mux_b_q   <= mux_b_d;
            alu_sel_q <= alu_sel_d;
            dec_sel_q <= dec_sel_d;
            we_q      <= we_d;
            done_q    <= done_d;
            err_q     <= err_d;
            cnt_q     <= cnt_d;
        end
    end

    assign SC_UDPSEQ_CmdReady_Out   = ready_q;
    assign SC_UDPSEQ_MuxA_Out       = mux_a_q;
    assign SC_UDPSEQ_MuxB_Out       = mux_b_q;
    assign SC_UDPSEQ_AluSel_Out     = alu_sel_q;
    assign SC_UDPSEQ_DecoderSel_Out = dec_sel_q;
    assign SC_UDPSEQ_WriteEn_Out    = we_q;
    assign SC_UDPSEQ_Done_Out       = done_q;
    assign SC_UDPSEQ_Error_Out      = err_q;
    assign SC_UDPSEQ_OpCount_Out    = cnt_q;

endmodule
